// File: rtl/sysid_verifier_if.sv
// Avalon-MM read-only master bus between sysid_verifier and the sysid slave.
interface sysid_verifier_if;
    logic        m_address;
    logic        m_read;
    logic        m_waitrequest;
    logic [31:0] m_readdata;

    modport master (
        output m_address,
        output m_read,
        input  m_waitrequest,
        input  m_readdata
    );

    modport slave (
        input  m_address,
        input  m_read,
        output m_waitrequest,
        output m_readdata
    );
endinterface

// File: rtl/sysid_verifier.sv
// Reads the sysid ID/timestamp words, compares them to expected values and retries on mismatch.
// Optional read timeout enabled by defining SYSID_VERIFIER_TIMEOUT_EN.
module sysid_verifier #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1766031671,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    sysid_verifier_if.master        m,
    output logic [31:0]             captured_id,
    output logic [31:0]             captured_ts,
    output logic                    busy,
    output logic                    done,
    output logic                    id_ok,
    output logic                    ts_ok,
    output logic                    error,
    output logic                    timeout,
    output logic [3:0]              retry_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        RD_TS,
        CHECK,
        PASS,
        FAIL
    } state_t;

    localparam logic [3:0] MAX_RC = 4'(MAX_RETRIES);

    state_t      state_q, state_d;
    logic        rd_q, rd_d;
    logic        addr_q, addr_d;
    logic        auto_q;
    logic [31:0] cid_q, cid_d;
    logic [31:0] cts_q, cts_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        err_q, err_d;
    logic        to_q, to_d;
    logic [3:0]  rc_q, rc_d;
    logic        go;

    // auto_q stands in for a start pulse on the first edge after reset release
    assign go = start || auto_q;

`ifdef SYSID_VERIFIER_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_cnt_q, to_cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        cid_d   = cid_q;
        cts_d   = cts_q;
        id_ok_d = id_ok_q;
        ts_ok_d = ts_ok_q;
        err_d   = err_q;
        to_d    = to_q;
        rc_d    = rc_q;

        case (state_q)
            IDLE, PASS, FAIL: begin
                if (go) begin
                    state_d = RD_ID;
                    rd_d    = 1'b1;
                    addr_d  = 1'b0;
                    id_ok_d = 1'b0;
                    ts_ok_d = 1'b0;
                    err_d   = 1'b0;
                    to_d    = 1'b0;
                    rc_d    = '0;
                end
            end
            RD_ID: begin
                if (!m.m_waitrequest) begin
                    cid_d   = m.m_readdata;
                    rd_d    = 1'b0;
                    state_d = RD_TS;
                end
            end
            RD_TS: begin
                // first RD_TS cycle is the mandatory idle gap between the two reads
                if (!rd_q) begin
                    rd_d   = 1'b1;
                    addr_d = 1'b1;
                end else if (!m.m_waitrequest) begin
                    cts_d   = m.m_readdata;
                    rd_d    = 1'b0;
                    addr_d  = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                id_ok_d = (cid_q == EXPECTED_ID);
                ts_ok_d = (cts_q == EXPECTED_TS);
                if ((cid_q == EXPECTED_ID) && (cts_q == EXPECTED_TS)) begin
                    state_d = PASS;
                end else if (rc_q < MAX_RC) begin
                    rc_d    = rc_q + 4'd1;
                    rd_d    = 1'b1;
                    addr_d  = 1'b0;
                    state_d = RD_ID;
                end else begin
                    err_d   = 1'b1;
                    state_d = FAIL;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef SYSID_VERIFIER_TIMEOUT_EN
        if (rd_q && m.m_waitrequest && (to_cnt_q == TO_LAST)) begin
            state_d = FAIL;
            rd_d    = 1'b0;
            addr_d  = 1'b0;
            to_d    = 1'b1;
            err_d   = 1'b1;
        end
        if (rd_d && !rd_q) begin
            to_cnt_d = '0;
        end else if (rd_q && m.m_waitrequest) begin
            to_cnt_d = to_cnt_q + 16'd1;
        end else begin
            to_cnt_d = to_cnt_q;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            addr_q  <= 1'b0;
            auto_q  <= AUTO_START;
            cid_q   <= '0;
            cts_q   <= '0;
            id_ok_q <= 1'b0;
            ts_ok_q <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            auto_q  <= 1'b0;
            cid_q   <= cid_d;
            cts_q   <= cts_d;
            id_ok_q <= id_ok_d;
            ts_ok_q <= ts_ok_d;
            err_q   <= err_d;
            to_q    <= to_d;
            rc_q    <= rc_d;
        end
    end

`ifdef SYSID_VERIFIER_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
    assign timeout = to_q;
`else
    assign timeout = 1'b0;
`endif

    assign m.m_read    = rd_q;
    assign m.m_address = addr_q;
    assign captured_id = cid_q;
    assign captured_ts = cts_q;
    assign busy        = (state_q == RD_ID) || (state_q == RD_TS) || (state_q == CHECK);
    assign done        = (state_q == PASS) || (state_q == FAIL);
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign error       = err_q;
    assign retry_cnt   = rc_q;

endmodule

// File: doc/sysid_verifier.md
SYSID_VERIFIER -- requirements
Module: sysid_verifier

Interface
REQ-001 Parameter EXPECTED_ID, default 32'd0, system ID word expected at sysid word address 0.
REQ-002 Parameter EXPECTED_TS, default 32'd1766031671, build timestamp expected at sysid word address 1.
REQ-003 Parameter MAX_RETRIES, default 3, range 0..15, number of re-read passes after a mismatch.
REQ-004 Parameter TIMEOUT_CYCLES, default 255, range 1..65535, waitrequest cycles tolerated per read.
REQ-005 Parameter AUTO_START, default 1, 1 = start a check automatically after reset release.
REQ-006 Port: clock  input  1  single clock for all logic.
REQ-007 Port: reset_n  input  1  reset, asynchronous and active-low.
REQ-008 Port: start  input  1  one-cycle request to begin a check.
REQ-009 Port: m_address  output  1  Avalon-MM master word address to the sysid slave.
REQ-010 Port: m_read  output  1  Avalon-MM master read strobe.
REQ-011 Port: m_waitrequest  input  1  slave stall; tie 0 for a zero-wait slave.
REQ-012 Port: m_readdata  input  32  slave read data, valid when m_read=1 and m_waitrequest=0.
REQ-013 Port: captured_id / captured_ts  output  32 each  last words read from addresses 0 / 1.
REQ-014 Port: busy, done, id_ok, ts_ok, error, timeout  output  1 each  status flags.
REQ-015 Port: retry_cnt  output  4  mismatch passes consumed in the current check.

Function
REQ-016 FSM states SHALL be IDLE, RD_ID, RD_TS, CHECK, PASS, FAIL.
REQ-017 IDLE: start=1 (or first cycle after reset release when AUTO_START=1) -> RD_ID, clearing retry_cnt, id_ok, ts_ok, error, timeout.
REQ-018 RD_ID: m_read=1, m_address=0; on m_waitrequest=0 capture m_readdata into captured_id and go to RD_TS next cycle.
REQ-019 RD_TS: m_read=1, m_address=1; on m_waitrequest=0 capture into captured_ts and go to CHECK.
REQ-020 m_read SHALL deassert for at least one cycle between the ID and TS transfers; no back-to-back reads.
REQ-021 CHECK (one cycle): register id_ok=(captured_id==EXPECTED_ID), ts_ok=(captured_ts==EXPECTED_TS) as full 32-bit compares.
REQ-022 CHECK: both ok -> PASS; else if retry_cnt<MAX_RETRIES -> retry_cnt+1, RD_ID; else -> FAIL with error=1.
REQ-023 MAX_RETRIES=0: first mismatch goes directly to FAIL.
REQ-024 busy=1 in RD_ID, RD_TS, CHECK; done=1 (level) in PASS and FAIL; error=1 only in FAIL.
REQ-025 start while busy SHALL be ignored; start in PASS/FAIL SHALL restart as from IDLE in the next cycle.
REQ-026 Minimum check latency with m_waitrequest=0: start at cycle N -> done=1 at cycle N+5.
REQ-027 m_address and m_read SHALL be registered outputs, glitch-free, stable while m_waitrequest=1.

Reset
REQ-028 Asserting reset_n=0 SHALL immediately force state IDLE, m_read=0, m_address=0, all flags 0, retry_cnt=0, captured_id=captured_ts=0, including mid-transfer.
REQ-029 First action after reset release: AUTO_START=1 -> RD_ID on first rising edge; AUTO_START=0 -> wait in IDLE.

Configuration
REQ-030 Macro SYSID_VERIFIER_TIMEOUT_EN: when defined, a 16-bit counter SHALL count cycles with m_read=1 and m_waitrequest=1, reloading at each read start.
REQ-031 With SYSID_VERIFIER_TIMEOUT_EN, counter reaching TIMEOUT_CYCLES SHALL drop m_read next cycle and enter FAIL with timeout=1, error=1, no retry.
REQ-032 Without SYSID_VERIFIER_TIMEOUT_EN, reads SHALL wait indefinitely, no counter SHALL be synthesized, timeout SHALL be constant 0.

Verification
REQ-033 AUTO_START=1, slave returns 0 / 1766031671, waitrequest=0 -> PASS, id_ok=ts_ok=1, error=0, retry_cnt=0, done 5 cycles after reset release.
REQ-034 TS returns 0x12345678 on every read, MAX_RETRIES=3 -> four read passes, FAIL, id_ok=1, ts_ok=0, retry_cnt=3, error=1.
REQ-035 TS wrong on first pass only -> PASS with retry_cnt=1, captured_ts=1766031671.
REQ-036 waitrequest held 3 cycles on each read -> m_read/m_address stable during stall, PASS at 11 cycles after start.
REQ-037 Macro defined, TIMEOUT_CYCLES=10, waitrequest stuck 1 -> FAIL, timeout=1, m_read=0; macro undefined -> busy stays 1, timeout=0.
REQ-038 reset_n pulsed low during RD_TS stall -> all outputs 0 same cycle; after release, fresh check completes PASS.
